// File: rtl/reorder_buffer_pkg.sv
// Shared LC-3b types and constants for the reorder buffer and its pointer logic.
package reorder_buffer_pkg;

  localparam int ID_W  = 4;
  localparam int REG_W = 4;

  typedef logic [ID_W-1:0]  lc3b_rob_id;
  typedef logic [REG_W-1:0] lc3b_ext_reg;
  typedef logic [15:0]      lc3b_word;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mispredict;
    lc3b_ext_reg dest;
    lc3b_word    value;
  } lc3b_rob_entry;

  // All-ones id is never allocated because 2^ID_W > DEPTH.
  localparam lc3b_rob_id  REORDER_ID_INVALID = '1;
  // Extended destinations beyond R0-R7.
  localparam lc3b_ext_reg REGISTER_PC        = 4'd8;
  localparam lc3b_ext_reg DUMMY_STORE        = 4'd9;

  // A tag names a real entry only if it is not the invalid id and below depth.
  function automatic logic tag_in_range(input lc3b_rob_id id, input int depth);
    return (id != REORDER_ID_INVALID) && (int'(id) < depth);
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the circular reorder buffer, including the
// realignment of both pointers when a mispredicted branch commits.
module rob_ptr_ctrl #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_fire,
  input  logic             commit_fire,
  input  logic             flush,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count;

  // Pointer and occupancy update; a flush commits the head and empties the
  // buffer, so the tail restarts just past the committed branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= head + 1'b1;
      tail  <= head + 1'b1;
      count <= '0;
    end else begin
      if (commit_fire) head <= head + 1'b1;
      if (alloc_fire)  tail <= tail + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order circular reorder buffer: allocates ids at issue, captures CDB
// results, retires the head in program order into the register file and
// raises flush/redirect when a mispredicted branch retires.
// Optional store handshake (store_ack/store_commit) is enabled by defining
// ROB_STORE_ACK_EN; without it stores retire like any other entry.
//
// Handshake: an allocation happens in a cycle where alloc_valid && alloc_ready;
// alloc_id is valid whenever alloc_ready is high. Commit and flush are
// single-cycle strobes with no back-pressure (except the optional store ack).
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               alloc_valid,
  input  lc3b_ext_reg        alloc_dest,
  output logic               alloc_ready,
  output lc3b_rob_id         alloc_id,
  input  logic               cdb_valid,
  input  lc3b_rob_id         cdb_rob_id,
  input  lc3b_word           cdb_value,
  input  logic               cdb_mispredict,
  input  lc3b_rob_id  [1:0]  rd_id,
  output logic        [1:0]  rd_ready,
  output lc3b_word    [1:0]  rd_value,
  output logic               rf_load_rob,
  output lc3b_ext_reg        rf_dest_rob,
  output lc3b_rob_id         rf_rob_in,
  output logic               rf_load_value,
  output lc3b_ext_reg        rf_dest_value,
  output lc3b_word           rf_value_in,
  output lc3b_rob_id         rf_value_rob,
  output logic               flush,
  output lc3b_word           redirect_pc
`ifdef ROB_STORE_ACK_EN
  ,
  input  logic               store_ack,
  output logic               store_commit
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  lc3b_rob_entry    entries [DEPTH];
  lc3b_rob_entry    head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             empty;
  lc3b_rob_id       head_id;
  lc3b_rob_id       tail_id;
  logic             head_ok;
  logic             commit_fire;
  logic             alloc_fire;
  logic             cdb_hit;
  logic [PTR_W-1:0] cdb_idx;

  rob_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc_fire  (alloc_fire),
    .commit_fire (commit_fire),
    .flush       (flush),
    .head        (head),
    .tail        (tail),
    .full        (full),
    .empty       (empty)
  );

  assign head_entry = entries[head];
  assign head_id    = {{(ID_W-PTR_W){1'b0}}, head};
  assign tail_id    = {{(ID_W-PTR_W){1'b0}}, tail};
  assign head_ok    = !empty && head_entry.busy && head_entry.done;

`ifdef ROB_STORE_ACK_EN
  // A completed store at the head waits for the memory side to accept it.
  assign store_commit = head_ok && (head_entry.dest == DUMMY_STORE);
  assign commit_fire  = head_ok && ((head_entry.dest != DUMMY_STORE) || store_ack);
`else
  assign commit_fire  = head_ok;
`endif

  assign flush       = commit_fire && head_entry.mispredict;
  assign alloc_ready = reset_n && !full && !flush;
  assign alloc_id    = reset_n ? tail_id : REORDER_ID_INVALID;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cdb_idx     = cdb_rob_id[PTR_W-1:0];
  assign cdb_hit     = cdb_valid && tag_in_range(cdb_rob_id, DEPTH) &&
                       entries[cdb_idx].busy && !flush;

  // Entry state: allocate at tail, complete from the CDB, retire at head;
  // a flush drops every in-flight entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].busy <= 1'b0;
    end else begin
      if (alloc_fire) begin
        entries[tail] <= '{busy: 1'b1, done: 1'b0, mispredict: 1'b0,
                           dest: alloc_dest, value: '0};
      end
      if (cdb_hit) begin
        entries[cdb_idx].done       <= 1'b1;
        entries[cdb_idx].value      <= cdb_value;
        entries[cdb_idx].mispredict <= cdb_mispredict;
      end
      if (commit_fire) entries[head].busy <= 1'b0;
    end
  end

  // Operand lookup with same-cycle CDB bypass taking priority over storage.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rd_ready[r] = 1'b0;
      rd_value[r] = '0;
      if (reset_n && tag_in_range(rd_id[r], DEPTH)) begin
        if (cdb_valid && (cdb_rob_id == rd_id[r])) begin
          rd_ready[r] = 1'b1;
          rd_value[r] = cdb_value;
        end else begin
          rd_ready[r] = entries[rd_id[r][PTR_W-1:0]].busy &&
                        entries[rd_id[r][PTR_W-1:0]].done;
          rd_value[r] = entries[rd_id[r][PTR_W-1:0]].value;
        end
      end
    end
  end

  // Register-file rename and commit strobes, plus the fetch redirect.
  always_comb begin
    rf_load_rob   = alloc_fire;
    rf_dest_rob   = alloc_fire ? alloc_dest : '0;
    rf_rob_in     = alloc_fire ? tail_id : REORDER_ID_INVALID;
    rf_load_value = commit_fire;
    rf_dest_value = commit_fire ? head_entry.dest : '0;
    rf_value_in   = commit_fire ? head_entry.value : '0;
    rf_value_rob  = commit_fire ? head_id : REORDER_ID_INVALID;
    redirect_pc   = flush ? head_entry.value : '0;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus queues the expected rename,
// commit and redirect records; a negedge monitor pops and compares them.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int P_NONE  = 0;
  localparam int P_RESET = 1;
  localparam int P_READY = 2;
  localparam int P_RD    = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              alloc_valid;
  lc3b_ext_reg       alloc_dest;
  logic              alloc_ready;
  lc3b_rob_id        alloc_id;
  logic              cdb_valid;
  lc3b_rob_id        cdb_rob_id;
  lc3b_word          cdb_value;
  logic              cdb_mispredict;
  lc3b_rob_id  [1:0] rd_id;
  logic        [1:0] rd_ready;
  lc3b_word    [1:0] rd_value;
  logic              rf_load_rob;
  lc3b_ext_reg       rf_dest_rob;
  lc3b_rob_id        rf_rob_in;
  logic              rf_load_value;
  lc3b_ext_reg       rf_dest_value;
  lc3b_word          rf_value_in;
  lc3b_rob_id        rf_value_rob;
  logic              flush;
  lc3b_word          redirect_pc;
`ifdef ROB_STORE_ACK_EN
  logic              store_commit;
`endif

  logic [7:0]  alloc_q[$];
  logic [23:0] commit_q[$];
  logic [15:0] flush_q[$];

  int          probe = P_NONE;
  logic        exp_ready;
  lc3b_rob_id  exp_id;
  logic [1:0]  exp_rd_ready;
  lc3b_word    exp_rd0;
  lc3b_word    exp_rd1;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alloc_valid    (alloc_valid),
    .alloc_dest     (alloc_dest),
    .alloc_ready    (alloc_ready),
    .alloc_id       (alloc_id),
    .cdb_valid      (cdb_valid),
    .cdb_rob_id     (cdb_rob_id),
    .cdb_value      (cdb_value),
    .cdb_mispredict (cdb_mispredict),
    .rd_id          (rd_id),
    .rd_ready       (rd_ready),
    .rd_value       (rd_value),
    .rf_load_rob    (rf_load_rob),
    .rf_dest_rob    (rf_dest_rob),
    .rf_rob_in      (rf_rob_in),
    .rf_load_value  (rf_load_value),
    .rf_dest_value  (rf_dest_value),
    .rf_value_in    (rf_value_in),
    .rf_value_rob   (rf_value_rob),
    .flush          (flush),
    .redirect_pc    (redirect_pc)
`ifdef ROB_STORE_ACK_EN
    ,
    .store_ack      (1'b1),
    .store_commit   (store_commit)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h expected=no_event at %0t", nm, act, $time);
  endtask

  // Monitor / scoreboard: compares every DUT output event with the queues.
  always @(negedge clk) begin
    logic [7:0]  ea;
    logic [23:0] ec;
    logic [15:0] ef;
    if (rf_load_rob) begin
      if (alloc_q.size() == 0) unexpected("alloc_unexpected", 32'(rf_rob_in));
      else begin
        ea = alloc_q.pop_front();
        chk("alloc_rename", 32'({rf_dest_rob, rf_rob_in}), 32'(ea));
      end
    end
    if (rf_load_value) begin
      if (commit_q.size() == 0) unexpected("commit_unexpected", 32'(rf_value_rob));
      else begin
        ec = commit_q.pop_front();
        chk("commit", 32'({rf_dest_value, rf_value_in, rf_value_rob}), 32'(ec));
      end
    end
    if (flush) begin
      if (flush_q.size() == 0) unexpected("flush_unexpected", 32'(redirect_pc));
      else begin
        ef = flush_q.pop_front();
        chk("redirect_pc", 32'(redirect_pc), 32'(ef));
      end
    end
    case (probe)
      P_RESET: begin
        chk("rst_alloc_ready", 32'(alloc_ready), 32'(0));
        chk("rst_alloc_id", 32'(alloc_id), 32'(15));
        chk("rst_rf_rob_in", 32'(rf_rob_in), 32'(15));
        chk("rst_rf_value_rob", 32'(rf_value_rob), 32'(15));
        chk("rst_strobes", 32'({rf_load_rob, rf_load_value, flush}), 32'(0));
        chk("rst_data", 32'({rf_dest_rob, rf_dest_value, rf_value_in}), 32'(0));
        chk("rst_redirect", 32'(redirect_pc), 32'(0));
        chk("rst_rd_ready", 32'(rd_ready), 32'(0));
      end
      P_READY: begin
        chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
        chk("alloc_id", 32'(alloc_id), 32'(exp_id));
      end
      P_RD: begin
        chk("rd_ready", 32'(rd_ready), 32'(exp_rd_ready));
        chk("rd_value0", 32'(rd_value[0]), 32'(exp_rd0));
        chk("rd_value1", 32'(rd_value[1]), 32'(exp_rd1));
      end
      default: ;
    endcase
    if (end_req && !end_done) begin
      chk("alloc_q_left", 32'(alloc_q.size()), 32'(0));
      chk("commit_q_left", 32'(commit_q.size()), 32'(0));
      chk("flush_q_left", 32'(flush_q.size()), 32'(0));
      end_done = 1'b1;
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
    probe = P_NONE;
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_dest     = '0;
    cdb_valid      = 1'b0;
    cdb_rob_id     = '0;
    cdb_value      = '0;
    cdb_mispredict = 1'b0;
    rd_id[0]       = '0;
    rd_id[1]       = '0;
  endtask

  task automatic ready_probe(input logic r, input lc3b_rob_id id);
    probe     = P_READY;
    exp_ready = r;
    exp_id    = id;
  endtask

  task automatic rd_probe(input logic [1:0] r, input lc3b_word v0, input lc3b_word v1);
    probe        = P_RD;
    exp_rd_ready = r;
    exp_rd0      = v0;
    exp_rd1      = v1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    probe   = P_RESET;
    cyc();
    reset_n = 1'b1;
    ready_probe(1'b1, 4'd0);
    cyc();
  endtask

  task automatic do_alloc(input lc3b_ext_reg dest, input lc3b_rob_id id);
    alloc_valid = 1'b1;
    alloc_dest  = dest;
    alloc_q.push_back({dest, id});
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cdb(input lc3b_rob_id id, input lc3b_word v, input logic mp);
    cdb_valid      = 1'b1;
    cdb_rob_id     = id;
    cdb_value      = v;
    cdb_mispredict = mp;
    cyc();
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    idle();
    reset_n = 1'b0;
    probe   = P_RESET;
    cyc();
    reset_n = 1'b1;
    ready_probe(1'b1, 4'd0);
    cyc();

    // Single alloc / complete / commit
    do_alloc(4'd3, 4'd0);
    commit_q.push_back({4'd3, 16'h1234, 4'd0});
    do_cdb(4'd0, 16'h1234, 1'b0);
    cyc();

    // Fill all eight entries, then free one
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(lc3b_ext_reg'(i), lc3b_rob_id'(i));
    ready_probe(1'b0, 4'd0);
    cyc();
    commit_q.push_back({4'd0, 16'h0A00, 4'd0});
    do_cdb(4'd0, 16'h0A00, 1'b0);
    ready_probe(1'b0, 4'd0);
    cyc();
    ready_probe(1'b1, 4'd0);
    cyc();

    // Reverse-order completion retires in program order (reset mid-operation)
    do_reset();
    do_alloc(4'd1, 4'd0);
    do_alloc(4'd2, 4'd1);
    do_alloc(4'd4, 4'd2);
    commit_q.push_back({4'd1, 16'h0F0F, 4'd0});
    commit_q.push_back({4'd2, 16'h1111, 4'd1});
    commit_q.push_back({4'd4, 16'h2222, 4'd2});
    do_cdb(4'd2, 16'h2222, 1'b0);
    do_cdb(4'd1, 16'h1111, 1'b0);
    do_cdb(4'd0, 16'h0F0F, 1'b0);
    repeat (4) cyc();

    // Operand reads: bypass, stale tag, invalid tag, stored value
    do_reset();
    do_alloc(4'd5, 4'd0);
    do_alloc(4'd6, 4'd1);
    cdb_valid  = 1'b1;
    cdb_rob_id = 4'd1;
    cdb_value  = 16'hBEEF;
    rd_id[0]   = 4'd1;
    rd_id[1]   = 4'd7;
    rd_probe(2'b01, 16'hBEEF, 16'h0000);
    cyc();
    cdb_valid = 1'b0;
    rd_id[1]  = 4'd15;
    rd_probe(2'b01, 16'hBEEF, 16'h0000);
    cyc();
    rd_id[0] = 4'd0;
    rd_id[1] = 4'd1;
    rd_probe(2'b10, 16'h0000, 16'hBEEF);
    cyc();
    idle();

    // Mispredicted branch at head flushes younger entries
    do_reset();
    do_alloc(REGISTER_PC, 4'd0);
    do_alloc(4'd1, 4'd1);
    do_alloc(4'd2, 4'd2);
    do_alloc(4'd3, 4'd3);
    commit_q.push_back({REGISTER_PC, 16'h0400, 4'd0});
    flush_q.push_back(16'h0400);
    do_cdb(4'd0, 16'h0400, 1'b1);
    cdb_valid  = 1'b1;
    cdb_rob_id = 4'd1;
    cdb_value  = 16'h5555;
    ready_probe(1'b0, 4'd4);
    cyc();
    cdb_valid = 1'b0;
    ready_probe(1'b1, 4'd1);
    cyc();
    rd_id[0] = 4'd1;
    rd_id[1] = 4'd2;
    rd_probe(2'b00, 16'h0000, 16'h0000);
    cyc();
    idle();
    do_alloc(4'd7, 4'd1);
    commit_q.push_back({4'd7, 16'h7777, 4'd1});
    do_cdb(4'd1, 16'h7777, 1'b0);
    cyc();

    // Wrap-around: 20 alloc/complete/commit rounds
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_alloc(lc3b_ext_reg'(i % 8), lc3b_rob_id'(i % 8));
      commit_q.push_back({lc3b_ext_reg'(i % 8), lc3b_word'(16'h1000 + i), lc3b_rob_id'(i % 8)});
      do_cdb(lc3b_rob_id'(i % 8), lc3b_word'(16'h1000 + i), 1'b0);
      ready_probe(1'b1, lc3b_rob_id'((i + 1) % 8));
      cyc();
    end

    // Final report
    end_req = 1'b1;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
